// File: rtl/iir_dec_outbuf.sv
// iir_dec_outbuf: decimating 16.16->8.8 output stage with show-ahead FIFO (IIR_DEC_ROUND_EN adds round-half-up)
module iir_dec_outbuf #(
  parameter int DEC = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] x_in,
  input  logic        x_valid,
  input  logic        y_ready,
  input  logic        clear_flags,
  output logic [15:0] y_out,
  output logic        y_valid,
  output logic        sat_flag,
  output logic [7:0]  ovr_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = DEC > 1 ? $clog2(DEC) : 1;
  logic [PW-1:0] phase;
  logic [32:0] xs;
  logic sat, keep, s1_keep, pop, full, wr, drop, unused_lsb;
  logic [15:0] conv, s1_data;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
`ifdef IIR_DEC_ROUND_EN
  assign xs = {x_in[31], x_in} + 33'd128;
`else
  assign xs = {x_in[31], x_in};
`endif
  assign unused_lsb = ^xs[7:0];
  // conversion, keep decision and FIFO handshake
  always_comb begin
    sat = ~(&xs[32:23] | ~|xs[32:23]);
    conv = sat ? (xs[32] ? 16'h8000 : 16'h7fff) : xs[23:8];
    keep = x_valid && phase == '0;
    y_valid = cnt != '0;
    y_out = y_valid ? mem[rp] : 16'h0;
    full = cnt == (AW+1)'(DEPTH);
    pop = y_valid && y_ready;
    wr = s1_keep && (!full || pop);
    drop = s1_keep && full && !pop;
  end
  // phase counter and stage-1 register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      s1_keep <= 1'b0;
      s1_data <= '0;
    end else begin
      if (x_valid) phase <= phase == PW'(DEC - 1) ? '0 : phase + 1'b1;
      s1_keep <= keep;
      s1_data <= conv;
    end
  end
  // FIFO storage; contents are discarded on reset through the pointers
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= s1_data;
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
  // sticky flags; a new event wins over a coincident clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag <= 1'b0;
      ovr_cnt <= '0;
    end else begin
      sat_flag <= (keep && sat) ? 1'b1 : clear_flags ? 1'b0 : sat_flag;
      ovr_cnt <= drop ? (clear_flags ? 8'd1 : ovr_cnt == 8'hff ? ovr_cnt : ovr_cnt + 8'd1) :
                 clear_flags ? 8'd0 : ovr_cnt;
    end
  end
endmodule

// File: doc/iir_dec_outbuf.md
IIR_DEC_OUTBUF -- requirements
Module: iir_dec_outbuf

Interface
REQ-001 SHALL have parameter DEC, default 2, decimation factor (legal range 1..16).
REQ-002 SHALL have parameter DEPTH, default 4, output FIFO depth in samples (power of 2, 2..16).
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port x_in, input, 32, signed 16.16 sample from the upstream lattice WDF output.
REQ-006 SHALL have port x_valid, input, 1, x_in holds a new sample this cycle.
REQ-007 SHALL have port y_ready, input, 1, downstream accepts y_out this cycle.
REQ-008 SHALL have port clear_flags, input, 1, synchronous clear of sat_flag and ovr_cnt.
REQ-009 SHALL have port y_out, output, 16, signed 8.8 decimated sample at FIFO head.
REQ-010 SHALL have port y_valid, output, 1, y_out is valid (FIFO not empty).
REQ-011 SHALL have port sat_flag, output, 1, sticky: at least one kept sample saturated.
REQ-012 SHALL have port ovr_cnt, output, 8, count of kept samples dropped on a full FIFO; saturates at 255.

Function
REQ-013 SHALL keep a phase counter 0..DEC-1, advanced only on x_valid and wrapping DEC-1 -> 0.
REQ-014 SHALL keep a sample only when x_valid=1 and phase=0, so the first valid sample after reset is kept; with DEC=1 every valid sample is kept.
REQ-015 SHALL convert 16.16 to 8.8 as x_in[23:8], saturating to 16'h7FFF / 16'h8000 when x_in[31:23] are not all equal.
REQ-016 SHALL register the converted sample and a keep flag in stage 1; stage 2 writes the sample into the FIFO.
REQ-017 SHALL make a kept sample visible on y_out with y_valid=1 two cycles after its x_valid cycle when the FIFO is empty.
REQ-018 SHALL operate the FIFO show-ahead: y_valid = not empty; pop when y_valid and y_ready.
REQ-019 SHALL pop with no effect when y_ready=1 and the FIFO is empty.
REQ-020 SHALL accept a write when the FIFO is full and a pop occurs in the same cycle; occupancy then stays DEPTH.
REQ-021 SHALL drop a write to a full FIFO with no pop, leave contents unchanged, and increment ovr_cnt (hold at 255).
REQ-022 SHALL wrap read/write pointers modulo DEPTH and track occupancy in a counter of width log2(DEPTH)+1.
REQ-023 SHALL set sat_flag in the stage-1 cycle of a kept, saturated sample.
REQ-024 SHALL give set precedence over clear_flags for sat_flag and ovr_cnt in the same cycle; the new event then applies to the cleared value (sat_flag=1, ovr_cnt=1).
REQ-025 SHALL never let x_valid be stalled by the FIFO; the block has no upstream backpressure.

Reset
REQ-026 SHALL on reset asynchronously clear phase, the stage-1 registers, FIFO pointers and occupancy, sat_flag, and ovr_cnt.
REQ-027 SHALL drive y_out=0 and y_valid=0 during reset and discard FIFO contents.
REQ-028 SHALL lose any in-flight stage-1 sample when reset is asserted mid-operation; the first valid sample after release is kept.

Configuration
REQ-029 SHALL, with IIR_DEC_ROUND_EN defined, add 128 to x_in in 33-bit signed arithmetic before slicing and saturating (round half up).
REQ-030 SHALL, without IIR_DEC_ROUND_EN, truncate (floor) as in REQ-015.

Verification
REQ-031 SHALL verify decimation and latency: DEC=2, y_ready=1, x_valid=1 every cycle, x_in=k<<16 for k=0,1,2,.. -> y_out=0x0000,0x0200,0x0400.. with first y_valid two cycles after the first x_valid.
REQ-032 SHALL verify saturation: x_in=32'h00800000 -> y_out=16'h7FFF, sat_flag=1; x_in=32'hFF000000 -> 16'h8000.
REQ-033 SHALL verify rounding: x_in=32'h00000080 -> y_out=0x0001 with IIR_DEC_ROUND_EN, 0x0000 without; x_in=32'hFFFFFF7F -> 0xFFFF in both builds.
REQ-034 SHALL verify overrun: DEPTH=4, DEC=1, y_ready=0, 6 kept samples -> y_valid=1, first 4 retained in order, ovr_cnt=2; simultaneous pop and push at full -> ovr_cnt unchanged.
REQ-035 SHALL verify flags and reset: clear_flags with no new saturation event -> sat_flag=0, ovr_cnt=0; clear_flags coincident with a saturating kept sample -> sat_flag stays 1; reset pulse with 3 samples in the FIFO -> y_valid=0 next cycle, phase restarts at 0.
